// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge responder: channel state encoding,
// disabled-trigger marker, vector widths and mode values.
package bridge_pkg;

  localparam int NCMD = 42;
  localparam int NSTS = 16;

  localparam logic [5:0] TRIG_OFF   = 6'h3F;
  localparam logic       MODE_PULSE = 1'b0;
  localparam logic       MODE_LEVEL = 1'b1;

  // Encoding chosen so bit 1 is the status level and bit 0 the countdown flag.
  typedef enum logic [1:0] {
    ST_LO      = 2'b00,
    ST_WAIT_HI = 2'b01,
    ST_HI      = 2'b10,
    ST_WAIT_LO = 2'b11
  } chan_state_t;

  function automatic logic state_sts(input chan_state_t s);
    return (s == ST_HI) || (s == ST_WAIT_LO);
  endfunction

  function automatic logic state_busy(input chan_state_t s);
    return (s == ST_WAIT_HI) || (s == ST_WAIT_LO);
  endfunction

endpackage

// File: rtl/bridge_resp_chan.sv
// One responder channel: config registers, delay counter and the
// LO/WAIT_HI/HI/WAIT_LO state machine driven by a pre-detected trigger.
module bridge_resp_chan
  import bridge_pkg::*;
#(
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [5:0]       cfg_trig,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic             cfg_mode,
  input  logic             hit,
  output logic [5:0]       trig,
  output logic             sts,
  output logic             busy,
  output chan_state_t      state
);

  logic [DLY_W-1:0] dly;
  logic             mode;
  logic [DLY_W-1:0] cnt;
  chan_state_t      next_state;
  logic [DLY_W-1:0] next_cnt;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_LO: begin
        if (hit) begin
          next_state = ST_WAIT_HI;
          next_cnt   = dly;
        end
      end
      ST_WAIT_HI: begin
        if (cnt == '0) next_state = ST_HI;
        else           next_cnt   = cnt - DLY_W'(1);
      end
      ST_HI: begin
        if (mode == MODE_PULSE) begin
          next_state = ST_LO;
        end else if (hit) begin
          next_state = ST_WAIT_LO;
          next_cnt   = dly;
        end
      end
      ST_WAIT_LO: begin
        if (cnt == '0) next_state = ST_LO;
        else           next_cnt   = cnt - DLY_W'(1);
      end
      default: begin
        next_state = ST_LO;
        next_cnt   = '0;
      end
    endcase
    // A config write discards any in-flight activity, including a same-cycle hit.
    if (cfg_wr) begin
      next_state = ST_LO;
      next_cnt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig  <= TRIG_OFF;
      dly   <= '0;
      mode  <= MODE_PULSE;
      state <= ST_LO;
      cnt   <= '0;
      sts   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (cfg_wr) begin
        trig <= cfg_trig;
        dly  <= cfg_dly;
        mode <= cfg_mode;
      end
      state <= next_state;
      cnt   <= next_cnt;
      sts   <= state_sts(next_state);
      busy  <= state_busy(next_state);
    end
  end

endmodule

// File: rtl/bridge_responder.sv
// Plant responder: registers the command vector for rising-edge detection,
// decodes config writes and routes each channel's selected command bit.
module bridge_responder
  import bridge_pkg::*;
#(
  parameter int DLY_W = 4,
  parameter int NCMD  = 42
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCMD-1:0]   cmd,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [5:0]        cfg_trig,
  input  logic [DLY_W-1:0]  cfg_dly,
  input  logic              cfg_mode,
  output logic [NSTS-1:0]   sts,
  output logic [NSTS-1:0]   busy,
  output logic [2*NSTS-1:0] dbg_state
);

  logic [NCMD-1:0] cmd_q;
  logic [NCMD-1:0] cmd_rise;

  always_ff @(posedge clk) begin
    if (rst) cmd_q <= '0;
    else     cmd_q <= cmd;
  end

  assign cmd_rise = cmd & ~cmd_q;

  for (genvar j = 0; j < NSTS; j++) begin : g_chan
    logic        chan_wr;
    logic        chan_hit;
    logic [5:0]  chan_trig;
    chan_state_t chan_st;

    assign chan_wr = cfg_we && (cfg_addr == 4'(j));

    // Indices at or beyond the vector width (including TRIG_OFF) never fire.
    always_comb begin
      chan_hit = 1'b0;
      if (int'(chan_trig) < NCMD) chan_hit = cmd_rise[chan_trig];
    end

    bridge_resp_chan #(.DLY_W(DLY_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .cfg_wr   (chan_wr),
      .cfg_trig (cfg_trig),
      .cfg_dly  (cfg_dly),
      .cfg_mode (cfg_mode),
      .hit      (chan_hit),
      .trig     (chan_trig),
      .sts      (sts[j]),
      .busy     (busy[j]),
      .state    (chan_st)
    );

    assign dbg_state[2*j +: 2] = chan_st;
  end

endmodule

// File: tb/tb_bridge_responder.sv
// Bench for bridge_responder: per-cycle vector rows, expected sts/busy queued
// at drive time and popped after the following rising edge.
module tb_bridge_responder;

  localparam int DLY_W = 4;
  localparam int NCMD  = 42;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCMD-1:0]   cmd;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [5:0]        cfg_trig;
  logic [DLY_W-1:0]  cfg_dly;
  logic              cfg_mode;
  logic [15:0]       sts;
  logic [15:0]       busy;
  logic [31:0]       dbg_state;

  typedef struct {
    logic            rst;
    logic [NCMD-1:0] cmd;
    logic            we;
    logic [3:0]      addr;
    logic [5:0]      trig;
    logic [3:0]      dly;
    logic            mode;
    logic [15:0]     es;
    logic [15:0]     eb;
  } vec_t;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bridge_responder #(.DLY_W(DLY_W), .NCMD(NCMD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_trig  (cfg_trig),
    .cfg_dly   (cfg_dly),
    .cfg_mode  (cfg_mode),
    .sts       (sts),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  function automatic vec_t mk(input logic r, input logic [NCMD-1:0] c,
                              input logic we, input logic [3:0] a,
                              input logic [5:0] t, input logic [3:0] d,
                              input logic m, input logic [15:0] es,
                              input logic [15:0] eb);
    vec_t v;
    v.rst = r; v.cmd = c; v.we = we; v.addr = a; v.trig = t;
    v.dly = d; v.mode = m; v.es = es; v.eb = eb;
    return v;
  endfunction

  function automatic vec_t cy(input logic [NCMD-1:0] c, input logic [15:0] es,
                              input logic [15:0] eb);
    return mk(1'b0, c, 1'b0, 4'd0, 6'd0, 4'd0, 1'b0, es, eb);
  endfunction

  task automatic apply(input vec_t v, input string name, input int row);
    logic [31:0] exp;
    @(negedge clk);
    rst = v.rst; cmd = v.cmd; cfg_we = v.we; cfg_addr = v.addr;
    cfg_trig = v.trig; cfg_dly = v.dly; cfg_mode = v.mode;
    exp_q.push_back({v.es, v.eb});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (sts !== exp[31:16]) begin
      errors++;
      $display("FAIL %s row %0d sts: got %h expected %h", name, row, sts, exp[31:16]);
    end
    checks++;
    if (busy !== exp[15:0]) begin
      errors++;
      $display("FAIL %s row %0d busy: got %h expected %h", name, row, busy, exp[15:0]);
    end
  endtask

  task automatic run(input vec_t t[$], input string name);
    foreach (t[i]) apply(t[i], name, i);
  endtask

  initial begin
    logic [NCMD-1:0] c0, c5, c32, rnd;
    logic [15:0] b3, b6, b8;
    vec_t t[$];

    c0 = '0; c0[0] = 1'b1;
    c5 = '0; c5[5] = 1'b1;
    c32 = '0; c32[32] = 1'b1;
    b3 = 16'h0008; b6 = 16'h0040; b8 = 16'h0100;

    rst = 1'b1; cmd = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_trig = '0; cfg_dly = '0; cfg_mode = 1'b0;

    // Reset with random command activity, then idle toggling with no config.
    t = {};
    for (int i = 0; i < 2; i++) begin
      rnd = {10'($urandom), 32'($urandom)};
      t.push_back(mk(1'b1, rnd, 1'b0, 4'd0, 6'd0, 4'd0, 1'b0, 16'h0, 16'h0));
    end
    for (int i = 0; i < 8; i++) begin
      rnd = {10'($urandom), 32'($urandom)};
      t.push_back(cy(rnd, 16'h0, 16'h0));
    end
    run(t, "reset_idle");

    // Pulse: ch6 trig=32 dly=3; held-high command gives one pulse, re-rise gives another.
    t = {};
    t.push_back(mk(1'b0, '0, 1'b1, 4'd6, 6'd32, 4'd3, 1'b0, 16'h0, 16'h0));
    t.push_back(cy('0,  16'h0, 16'h0));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, b6,    16'h0));
    t.push_back(cy(c32, 16'h0, 16'h0));
    t.push_back(cy('0,  16'h0, 16'h0));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy('0,  16'h0, b6));
    t.push_back(cy('0,  16'h0, b6));
    t.push_back(cy('0,  16'h0, b6));
    t.push_back(cy('0,  b6,    16'h0));
    t.push_back(cy('0,  16'h0, 16'h0));
    run(t, "pulse");

    // Second rise during WAIT_HI is dropped: a single pulse.
    t = {};
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy('0,  16'h0, b6));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, 16'h0, b6));
    t.push_back(cy(c32, b6,    16'h0));
    t.push_back(cy(c32, 16'h0, 16'h0));
    t.push_back(cy('0,  16'h0, 16'h0));
    t.push_back(cy('0,  16'h0, 16'h0));
    run(t, "dropped");

    // Level toggle: ch8 trig=0 dly=0 mode=1.
    t = {};
    t.push_back(mk(1'b0, '0, 1'b1, 4'd8, 6'd0, 4'd0, 1'b1, 16'h0, 16'h0));
    t.push_back(cy(c0, 16'h0, b8));
    for (int i = 0; i < 6; i++) t.push_back(cy('0, b8, 16'h0));
    t.push_back(cy(c0, b8,    b8));
    t.push_back(cy('0, 16'h0, 16'h0));
    t.push_back(cy('0, 16'h0, 16'h0));
    run(t, "level");

    // Other-channel write leaves ch3 alone; same-cycle write and rise on ch3: write wins.
    apply(mk(1'b0, '0, 1'b1, 4'd3, 6'd5, 4'd0, 1'b1, 16'h0, 16'h0), "collision", 0);
    apply(cy(c5, 16'h0, b3), "collision", 1);
    apply(cy('0, b3, 16'h0), "collision", 2);
    apply(mk(1'b0, '0, 1'b1, 4'd9, 6'd1, 4'd2, 1'b0, b3, 16'h0), "collision", 3);
    apply(mk(1'b0, c5, 1'b1, 4'd3, 6'd5, 4'd0, 1'b1, 16'h0, 16'h0), "collision", 4);
    apply(cy(c5, 16'h0, 16'h0), "collision", 5);
    apply(cy('0, 16'h0, 16'h0), "collision", 6);

    // Reset mid-countdown: ch6 with two cycles left, then all config disabled.
    apply(cy('0,  16'h0, 16'h0), "reset_midop", 0);
    apply(cy(c32, 16'h0, b6),    "reset_midop", 1);
    apply(cy(c32, 16'h0, b6),    "reset_midop", 2);
    apply(mk(1'b1, c32, 1'b0, 4'd0, 6'd0, 4'd0, 1'b0, 16'h0, 16'h0), "reset_midop", 3);
    apply(cy('0,  16'h0, 16'h0), "reset_midop", 4);
    apply(cy(c32, 16'h0, 16'h0), "reset_midop", 5);
    apply(cy(c32 | c0 | c5, 16'h0, 16'h0), "reset_midop", 6);
    apply(cy('0,  16'h0, 16'h0), "reset_midop", 7);
    apply(cy('0,  16'h0, 16'h0), "reset_midop", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_responder.md
# bridge_responder

Programmable plant responder that sits on the far side of the bridge controller's command/status interface. It samples the 42-bit command vector, and each of 16 independent channels turns a selected command bit into a delayed status bit back to the controller. Benches use it to close the loop on controller benchmarks, including the trojan-inserted variants, so that multi-state sequences run without hand-written stimulus.

## Interface
Parameters:
- `DLY_W`, 4: width of per-channel delay field; delays 0..2^DLY_W-1 cycles.
- `NCMD`, 42: command vector width; trigger indices >= NCMD mean channel disabled.

Ports:
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd` in NCMD: command vector from controller; bit i corresponds to controller output y(i+1).
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in 4: channel index to configure.
- `cfg_trig` in 6: command bit index that triggers the channel.
- `cfg_dly` in DLY_W: response delay.
- `cfg_mode` in 1: 0 = pulse, 1 = level (toggle).
- `sts` out 16: status vector to controller; bit j drives controller input x(j+1).
- `busy` out 16: channel j has a delay countdown in progress.

## Operation
- Per channel, registered config: trig (reset 6'h3F = disabled), dly (reset 0), mode (reset 0).
- Trigger event for channel j: `cmd[trig_j]` is 1 this cycle and was 0 the previous cycle (rising edge; `cmd` registered once internally for edge detect, registered copy resets to 0). Disabled channels never trigger.
- Channel FSM, four states, reset to LO:
  - LO: sts=0, busy=0. Trigger -> WAIT_HI, counter <= dly.
  - WAIT_HI: sts=0, busy=1. Counter==0 -> HI; else counter decrements.
  - HI: sts=1, busy=0. Pulse mode: -> LO unconditionally (1-cycle high). Level mode: trigger -> WAIT_LO, counter <= dly.
  - WAIT_LO: sts=1, busy=1. Counter==0 -> LO; else decrements.
- Triggers arriving in WAIT_HI or WAIT_LO are dropped (no queuing).
- Config write to channel j: loads trig/dly/mode and forces channel j to LO (sts_j=0, busy_j=0) next cycle; in-flight countdown discarded. A trigger on the same channel in the same cycle is dropped — write wins.
- Writes to other channels leave channel j untouched.
- `rst` in any state: all config to reset values, all FSMs to LO, all outputs 0 on the next edge.

## Timing
- Trigger sampled at edge N (cmd rises between N-1 and N): state enters WAIT_HI at N; sts rises at edge N+1+dly. With dly=0, sts high one cycle after trigger edge.
- Pulse mode: sts high for exactly 1 cycle; next trigger accepted from the cycle sts returns low.
- Level mode: sts falls at edge M+1+dly after the second trigger edge M.
- `sts` and `busy` are register outputs; no combinational path from `cmd` or `cfg_*`.
- Config write at edge N takes effect for trigger detection from edge N+1.
- Command bit held high continuously gives exactly one trigger.

## Structure
- Shared package `bridge_pkg`: state enum (LO, WAIT_HI, HI, WAIT_LO), `TRIG_OFF = 6'h3F`, `NCMD`, `NSTS = 16`, mode constants.
- Sub-module `bridge_resp_chan`: one channel (config regs, edge-detected trigger input, counter, FSM); top instantiates 16 with a generate loop, does the shared `cmd` registering, trigger mux and cfg address decode.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with random `cmd` -> `sts`=0, `busy`=0; afterwards with no config, toggling any cmd bit leaves `sts`=0.
- Pulse: cfg ch6 trig=32, dly=3, mode=0; raise cmd[32] at edge 10 -> busy[6]=1 edges 10–13, sts[6]=1 only at edge 14.
- Level toggle: cfg ch8 trig=0, dly=0, mode=1; pulse cmd[0] at edges 5 and 12 -> sts[8] high edges 6–12, low from edge 13.
- Dropped trigger: ch6 as above; second cmd[32] rise at edge 12 (during WAIT_HI) -> only one sts[6] pulse at 14.
- Write/trigger collision: cfg write to ch3 at the same edge cmd[trig_3] rises -> sts[3] stays 0, busy[3]=0.
- Reset mid-op: ch6 in WAIT_HI with 2 cycles left, assert `rst` -> sts/busy 0 next edge, ch6 config back to disabled.
